// File: rtl/common_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : common_types_pkg
//  Description : Shared type definitions for the iterative divider controller.
//  Revision    : 1.0  - initial release
// ============================================================================
package common_types_pkg;

    // Controller states: accept, iterate, sign correction, hold result
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2,
        DONE   = 2'd3
    } divider_pipe_state_t;

endpackage
`default_nettype wire

// File: rtl/divider_pipe_ctrl_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One radix-2 restoring division step (combinational).
//                Shifts the next dividend bit into the partial remainder,
//                trial-subtracts the divisor and retires one quotient bit
//                into the low end of the dividend shift register.
//  Revision    : 1.0  - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,   // partial remainder, always < div_i
    input  logic [WIDTH-1:0] dvd_i,   // dividend bits (MSB next) / quotient bits
    input  logic [WIDTH-1:0] div_i,   // divisor magnitude
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o
);

    logic [WIDTH:0] shift_rem;
    logic [WIDTH:0] trial;
    logic           q_bit;

    // Trial subtraction; a clear borrow bit means the divisor fits
    always_comb begin
        shift_rem = {rem_i, dvd_i[WIDTH-1]};
        trial     = shift_rem - {1'b0, div_i};
        q_bit     = ~trial[WIDTH];
        // Because rem_i < div_i, the restored or reduced remainder fits WIDTH bits
        rem_o     = q_bit ? trial[WIDTH-1:0] : shift_rem[WIDTH-1:0];
        dvd_o     = {dvd_i[WIDTH-2:0], q_bit};
    end

endmodule
`default_nettype wire

// File: rtl/divider_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : divider_pipe_ctrl
//  Description : Iterative signed/unsigned restoring divider with a
//                valid/ready request side, valid/ready result side and a
//                flush that abandons the operation in flight. Retires UNROLL
//                quotient bits per cycle using a chain of div_step stages.
//  Revision    : 1.0  - initial release
// ============================================================================
module divider_pipe_ctrl
    import common_types_pkg::*;
#(
    parameter int WIDTH  = 32,   // operand width, >= 8 and even
    parameter int UNROLL = 1     // quotient bits per cycle: 1, 2 or 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               STEPS    = WIDTH / UNROLL;
    localparam int               CNT_W    = $clog2(STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    divider_pipe_state_t state_q;
    logic [CNT_W-1:0]    cnt_q;        // remaining DIVIDE cycles minus one
    logic [WIDTH-1:0]    rem_q;        // partial remainder
    logic [WIDTH-1:0]    dvd_q;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]    dsr_q;        // divisor magnitude
    logic                neg_quo_q;    // quotient needs negation
    logic                neg_rem_q;    // remainder needs negation
    logic [WIDTH-1:0]    q_q;
    logic [WIDTH-1:0]    r_q;
    logic                dbz_q;
    logic                ovf_q;
    logic                in_ready_q;
    logic                out_valid_q;

    // Next-state values of the iteration registers from the step chain
    logic [WIDTH-1:0]    rem_d;
    logic [WIDTH-1:0]    dvd_d;

    // Accept-time decode of the request operands
    logic                a_neg;
    logic                b_neg;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;
    logic                b_zero;
    logic                is_ovf;

    // Classify the request and form operand magnitudes before latching
    always_comb begin
        a_neg  = is_signed & a[WIDTH-1];
        b_neg  = is_signed & b[WIDTH-1];
        // The most-negative dividend negates to itself, which is the correct
        // unsigned magnitude 2^(WIDTH-1)
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        b_zero = (b == '0);
        // Only the signed most-negative / -1 case overflows; unsigned
        // all-ones divisors are ordinary divisions
        is_ovf = is_signed && (a == MOST_NEG) && (b == ALL_ONES);
    end

    // ------------------------------------------------------------------
    // UNROLL restoring steps chained within a single cycle
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
        logic [WIDTH-1:0] rem_in;
        logic [WIDTH-1:0] dvd_in;
        logic [WIDTH-1:0] rem_out;
        logic [WIDTH-1:0] dvd_out;

        if (gi == 0) begin : g_first
            assign rem_in = rem_q;
            assign dvd_in = dvd_q;
        end else begin : g_next
            assign rem_in = g_step[gi-1].rem_out;
            assign dvd_in = g_step[gi-1].dvd_out;
        end

        div_step #(
            .WIDTH (WIDTH)
        ) u_div_step (
            .rem_i (rem_in),
            .dvd_i (dvd_in),
            .div_i (dsr_q),
            .rem_o (rem_out),
            .dvd_o (dvd_out)
        );
    end

    assign rem_d = g_step[UNROLL-1].rem_out;
    assign dvd_d = g_step[UNROLL-1].dvd_out;

    // ------------------------------------------------------------------
    // Controller FSM with registered handshake and result outputs
    // ------------------------------------------------------------------
    // Sequence the operation and hold every visible output in a register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        neg_quo_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        in_ready_q <= 1'b0;
                        if (b_zero) begin
                            // Divide by zero resolves immediately
                            q_q         <= ALL_ONES;
                            r_q         <= a;
                            dbz_q       <= 1'b1;
                            ovf_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (is_ovf) begin
                            // Signed overflow resolves immediately
                            q_q         <= a;
                            r_q         <= '0;
                            dbz_q       <= 1'b0;
                            ovf_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            rem_q   <= '0;
                            dvd_q   <= a_mag;
                            dsr_q   <= b_mag;
                            cnt_q   <= CNT_LAST;
                            dbz_q   <= 1'b0;
                            ovf_q   <= 1'b0;
                            state_q <= DIVIDE;
                        end
                    end
                end

                DIVIDE: begin
                    if (flush) begin
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        if (cnt_q == '0) begin
                            state_q <= FIXUP;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end

                FIXUP: begin
                    if (flush) begin
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        // Quotient sign follows the operand signs; the
                        // remainder takes the sign of the dividend
                        q_q         <= neg_quo_q ? -dvd_q : dvd_q;
                        r_q         <= neg_rem_q ? -rem_q : rem_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end

                DONE: begin
                    // Leave through IDLE so no request is taken in the
                    // same cycle the result is consumed
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_pipe_ctrl
//  Description : Self-checking bench for divider_pipe_ctrl. Unit 0 runs
//                WIDTH=32/UNROLL=1, unit 1 runs WIDTH=32/UNROLL=4. Results
//                are compared with an arithmetic reference model.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_divider_pipe_ctrl;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    typedef struct packed {
        logic        in_ready;
        logic        out_valid;
        logic        dbz;
        logic        ovf;
        logic [31:0] q;
        logic [31:0] r;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst_v      [2];
    logic        in_valid_v  [2];
    logic [31:0] a_v         [2];
    logic [31:0] b_v         [2];
    logic        sgn_v       [2];
    logic        flush_v     [2];
    logic        out_ready_v [2];

    logic        in_ready_0, out_valid_0, dbz_0, ovf_0;
    logic [31:0] q_0, r_0;
    logic        in_ready_1, out_valid_1, dbz_1, ovf_1;
    logic [31:0] q_1, r_1;

    int checks = 0;
    int errors = 0;

    divider_pipe_ctrl #(.WIDTH(32), .UNROLL(1)) u_dut1 (
        .clk (clk), .nrst (nrst_v[0]), .in_valid (in_valid_v[0]), .in_ready (in_ready_0),
        .a (a_v[0]), .b (b_v[0]), .is_signed (sgn_v[0]), .flush (flush_v[0]),
        .out_valid (out_valid_0), .out_ready (out_ready_v[0]), .q (q_0), .r (r_0),
        .div_by_zero (dbz_0), .overflow (ovf_0)
    );

    divider_pipe_ctrl #(.WIDTH(32), .UNROLL(4)) u_dut4 (
        .clk (clk), .nrst (nrst_v[1]), .in_valid (in_valid_v[1]), .in_ready (in_ready_1),
        .a (a_v[1]), .b (b_v[1]), .is_signed (sgn_v[1]), .flush (flush_v[1]),
        .out_valid (out_valid_1), .out_ready (out_ready_v[1]), .q (q_1), .r (r_1),
        .div_by_zero (dbz_1), .overflow (ovf_1)
    );

    function automatic obs_t ob(input int u);
        obs_t o;
        if (u == 0) o = {in_ready_0, out_valid_0, dbz_0, ovf_0, q_0, r_0};
        else        o = {in_ready_1, out_valid_1, dbz_1, ovf_1, q_1, r_1};
        return o;
    endfunction

    // Reference model straight from the arithmetic definition
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ov);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else if (s && a == MIN_NEG && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0; ov = 1'b1;
        end else if (s) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    function automatic int exp_lat(input int u, input logic dz, input logic ov);
        if (dz || ov) return 1;
        return (u == 0) ? 34 : 10;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic apply_reset(input int u);
        @(negedge clk);
        nrst_v[u] = 1'b0;
        @(posedge clk);
        #1;
        nrst_v[u] = 1'b1;
    endtask

    // Present a request for one edge, then scramble the inputs
    task automatic start_op(input int u, input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        in_valid_v[u] = 1'b1;
        a_v[u] = a;
        b_v[u] = b;
        sgn_v[u] = s;
        @(posedge clk);
        #1;
        in_valid_v[u] = 1'b0;
        a_v[u] = $urandom;
        b_v[u] = $urandom;
        sgn_v[u] = 1'($urandom);
    endtask

    // Count edges from the accept edge until out_valid is seen (bounded)
    task automatic wait_done(input int u, output int lat);
        obs_t o;
        lat = 1;
        o = ob(u);
        while (!o.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            o = ob(u);
        end
    endtask

    task automatic release_out(input int u);
        @(negedge clk);
        out_ready_v[u] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[u] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        obs_t o;
        for (int u = 0; u < 2; u++) begin
            apply_reset(u);
            o = ob(u);
            checks++;
            if (o !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
                errors++;
                $display("FAIL reset u%0d: got rdy=%b vld=%b dz=%b ov=%b q=%h r=%h, expected rdy=1 vld=0 dz=0 ov=0 q=0 r=0",
                         u, o.in_ready, o.out_valid, o.dbz, o.ovf, o.q, o.r);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h1234, MIN_NEG, MIN_NEG};
        logic [31:0] tb [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic        ts [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] tq [6] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, MIN_NEG, 32'd0};
        logic [31:0] tr [6] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'h1234, 32'd0, MIN_NEG};
        logic        tz [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        tv [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int          tl [6] = '{34, 34, 34, 1, 1, 34};
        obs_t o;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            start_op(0, ta[i], tb[i], ts[i]);
            wait_done(0, lat);
            o = ob(0);
            checks++;
            if ({o.dbz, o.ovf, o.q, o.r} !== {tz[i], tv[i], tq[i], tr[i]}) begin
                errors++;
                $display("FAIL directed[%0d]: got q=%h r=%h dz=%b ov=%b, expected q=%h r=%h dz=%b ov=%b",
                         i, o.q, o.r, o.dbz, o.ovf, tq[i], tr[i], tz[i], tv[i]);
            end
            checks++;
            if (lat != tl[i]) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d edges, expected %0d", i, lat, tl[i]);
            end
            release_out(0);
            o = ob(0);
            checks++;
            if ({o.in_ready, o.out_valid} !== 2'b10) begin
                errors++;
                $display("FAIL directed_release[%0d]: got rdy=%b vld=%b, expected rdy=1 vld=0", i, o.in_ready, o.out_valid);
            end
        end
    endtask

    task automatic test_back_pressure();
        obs_t o;
        int   lat;
        int   bad;
        start_op(0, 32'd1000, 32'd33, 1'b0);
        wait_done(0, lat);
        // Hold the result for five cycles, with flush asserted (no effect in DONE)
        bad = 0;
        flush_v[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            o = ob(0);
            if (o !== {1'b0, 1'b1, 1'b0, 1'b0, 32'd30, 32'd10}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: got %0d unstable cycles (last rdy=%b vld=%b q=%h r=%h), expected 0 (rdy=0 vld=1 q=1e r=a)",
                     bad, o.in_ready, o.out_valid, o.q, o.r);
        end
        // Consume while a new request is already waiting: it must not be taken
        @(negedge clk);
        flush_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        in_valid_v[0] = 1'b1;
        a_v[0] = 32'd9;
        b_v[0] = 32'd3;
        sgn_v[0] = 1'b0;
        @(posedge clk);
        #1;
        out_ready_v[0] = 1'b0;
        in_valid_v[0] = 1'b0;
        o = ob(0);
        checks++;
        if ({o.in_ready, o.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL release_no_accept: got rdy=%b vld=%b, expected rdy=1 vld=0", o.in_ready, o.out_valid);
        end
        @(posedge clk);
        #1;
        o = ob(0);
        checks++;
        if ({o.in_ready, o.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL idle_after_release: got rdy=%b vld=%b, expected rdy=1 vld=0", o.in_ready, o.out_valid);
        end
    endtask

    task automatic test_flush();
        obs_t o;
        int   lat;
        int   seen;
        // Flush in IDLE must not block the accept
        flush_v[0] = 1'b1;
        start_op(0, 32'd1000, 32'd3, 1'b0);
        flush_v[0] = 1'b0;
        o = ob(0);
        checks++;
        if (o.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_accept: got rdy=%b, expected rdy=0", o.in_ready);
        end
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush_v[0] = 1'b1;
        @(posedge clk);
        #1;
        flush_v[0] = 1'b0;
        o = ob(0);
        checks++;
        if ({o.in_ready, o.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL flush_divide: got rdy=%b vld=%b, expected rdy=1 vld=0", o.in_ready, o.out_valid);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid_0 !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_result: got %0d cycles with out_valid, expected 0", seen);
        end
        // Flush while in FIXUP (32 edges after accept)
        start_op(0, 32'd77, 32'd5, 1'b0);
        repeat (32) @(posedge clk);
        @(negedge clk);
        flush_v[0] = 1'b1;
        @(posedge clk);
        #1;
        flush_v[0] = 1'b0;
        o = ob(0);
        checks++;
        if ({o.in_ready, o.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL flush_fixup: got rdy=%b vld=%b, expected rdy=1 vld=0", o.in_ready, o.out_valid);
        end
        start_op(0, 32'd9, 32'd3, 1'b0);
        wait_done(0, lat);
        o = ob(0);
        checks++;
        if ({o.q, o.r, lat} !== {32'd3, 32'd0, 32'd34}) begin
            errors++;
            $display("FAIL after_flush: got q=%h r=%h lat=%0d, expected q=3 r=0 lat=34", o.q, o.r, lat);
        end
        release_out(0);
    endtask

    task automatic test_unroll4();
        obs_t o;
        int   lat;
        int   seen;
        start_op(1, 32'hFFFF_FFFF, 32'd3, 1'b0);
        wait_done(1, lat);
        o = ob(1);
        checks++;
        if ({o.dbz, o.ovf, o.q, o.r} !== {1'b0, 1'b0, 32'h5555_5555, 32'd0}) begin
            errors++;
            $display("FAIL unroll4_result: got q=%h r=%h dz=%b ov=%b, expected q=55555555 r=0 dz=0 ov=0",
                     o.q, o.r, o.dbz, o.ovf);
        end
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL unroll4_latency: got %0d edges, expected 10", lat);
        end
        release_out(1);
        start_op(1, 32'd12345, 32'd11, 1'b0);
        repeat (2) @(posedge clk);
        apply_reset(1);
        o = ob(1);
        checks++;
        if (o !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid_divide: got rdy=%b vld=%b q=%h r=%h, expected rdy=1 vld=0 q=0 r=0",
                     o.in_ready, o.out_valid, o.q, o.r);
        end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid_1 !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_result: got %0d cycles with out_valid, expected 0", seen);
        end
    endtask

    task automatic test_random(input int u);
        obs_t        o;
        int          lat;
        int          mode;
        logic [31:0] a, b, eq, er;
        logic        s, ez, ev;
        for (int i = 0; i < 30; i++) begin
            mode = int'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case (mode)
                0: b = 32'd0;
                1: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: begin a = $urandom_range(0, 100); b = $urandom_range(1, 20) | 32'hFFFF_FF00; end
                4: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(a, b, s, eq, er, ez, ev);
            start_op(u, a, b, s);
            wait_done(u, lat);
            o = ob(u);
            checks++;
            if ({o.dbz, o.ovf, o.q, o.r} !== {ez, ev, eq, er}) begin
                errors++;
                $display("FAIL random u%0d [%0d] a=%h b=%h s=%b: got q=%h r=%h dz=%b ov=%b, expected q=%h r=%h dz=%b ov=%b",
                         u, i, a, b, s, o.q, o.r, o.dbz, o.ovf, eq, er, ez, ev);
            end
            checks++;
            if (lat != exp_lat(u, ez, ev)) begin
                errors++;
                $display("FAIL random_latency u%0d [%0d]: got %0d edges, expected %0d", u, i, lat, exp_lat(u, ez, ev));
            end
            release_out(u);
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            nrst_v[u] = 1'b0;
            in_valid_v[u] = 1'b0;
            a_v[u] = '0;
            b_v[u] = '0;
            sgn_v[u] = 1'b0;
            flush_v[u] = 1'b0;
            out_ready_v[u] = 1'b0;
        end
        repeat (2) @(posedge clk);
        test_reset();
        test_directed();
        test_back_pressure();
        test_flush();
        test_unroll4();
        test_random(0);
        test_random(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/divider_pipe_ctrl.md
DIVIDER_PIPE_CTRL -- requirements
Module: divider_pipe_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (>=8, even).
REQ-002 SHALL have parameter UNROLL, default 1, quotient bits retired per cycle (1, 2 or 4; must divide WIDTH).
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port nrst  input  1  synchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid&&in_ready at a rising edge.
REQ-008 SHALL have ports a, b  input  WIDTH  dividend, divisor.
REQ-009 SHALL have port is_signed  input  1  two's-complement operation.
REQ-010 SHALL have port flush  input  1  abandon the in-flight operation.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have ports q, r  output  WIDTH  quotient, remainder.
REQ-014 SHALL have ports div_by_zero, overflow  output  1  exception flags qualified by out_valid.

Function
REQ-015 SHALL use states IDLE, DIVIDE, FIXUP, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL latch a, b, is_signed and the operand signs on accept; later changes to the inputs SHALL NOT affect the result.
REQ-017 SHALL, on accept with b==0, go IDLE->DONE with q=all ones, r=a, div_by_zero=1.
REQ-018 SHALL, on accept with is_signed, a=most-negative, b=all ones, go IDLE->DONE with q=a, r=0, overflow=1.
REQ-019 SHALL otherwise go IDLE->DIVIDE, loading magnitudes |a| and |b| (signed) or the raw a and b (unsigned).
REQ-020 SHALL perform restoring division in DIVIDE at UNROLL bits/cycle for exactly N=WIDTH/UNROLL cycles, then enter FIXUP.
REQ-021 SHALL, in FIXUP, register q negated iff signed and the operand signs differ, and r negated iff signed and a was negative (remainder takes the dividend's sign), then enter DONE.
REQ-022 SHALL hold the normal-path latency at N+2 edges from the accept edge to out_valid visible; special-case latency SHALL be 1 edge.
REQ-023 SHALL drive q, r and the flags from registers only, stable while in DONE.
REQ-024 SHALL stay in DONE while out_ready=0 and go DONE->IDLE on the edge with out_ready=1; a new request SHALL NOT be accepted in that same cycle.
REQ-025 SHALL, when flush=1 in DIVIDE or FIXUP, return to IDLE on the next edge with no out_valid pulse; flush in IDLE or DONE SHALL have no effect.
REQ-026 SHALL give flush priority over the DIVIDE/FIXUP state advance.
REQ-027 SHALL make an unsigned all-ones divisor a normal division, never an overflow.

Reset
REQ-028 SHALL, when nrst=0 at an edge, enter IDLE and clear q, r, the flags and the internal registers to 0, so that out_valid=0 and in_ready=1 after reset.
REQ-029 SHALL abandon any in-flight operation when reset is asserted mid-operation, without producing a result.

Structure
REQ-030 SHALL take the state enum divider_pipe_state_t from common_types_pkg.
REQ-031 SHALL implement one radix-2 restoring step as the combinational sub-module div_step, parameterised by WIDTH.
REQ-032 SHALL instantiate div_step UNROLL times in a chain.

Verification
REQ-033 SHALL cover, at WIDTH=32, UNROLL=1: unsigned 100/7 -> q=14, r=2, out_valid 34 edges after accept.
REQ-034 SHALL cover signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=1.
REQ-035 SHALL cover 0x1234/0 -> q=0xFFFFFFFF, r=0x1234, div_by_zero=1, after 1 edge; signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, overflow=1; the same operands unsigned -> q=0, r=0x80000000, no flag.
REQ-036 SHALL cover holding out_ready=0 for 5 cycles -> outputs stable and in_ready=0, then out_ready=1 -> IDLE next edge.
REQ-037 SHALL cover flush 10 cycles into DIVIDE -> IDLE next edge with no out_valid, then 9/3 -> q=3, r=0.
REQ-038 SHALL cover, at UNROLL=4: 0xFFFFFFFF/3 unsigned -> q=0x55555555, r=0, latency 10 edges; nrst pulsed mid-DIVIDE -> IDLE with outputs zero.
